// File: rtl/memguard_regulator.sv
// Per-queue budget regulator with fixed-priority arbitration over a programmable period.
// Optional slack reclamation when MEMGUARD_RECLAIM_EN is defined.
module memguard_regulator #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 16,
    parameter int PRIORITY_SIZE    = 4,
    parameter int PERIOD_SIZE      = 16
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [NUMBER_OF_QUEUES*REGISTER_SIZE-1:0]  budgets,
    input  logic [NUMBER_OF_QUEUES*PRIORITY_SIZE-1:0]  priorities,
    input  logic [PERIOD_SIZE-1:0]                     period,
    input  logic [NUMBER_OF_QUEUES-1:0]                empty,
    input  logic                                       update,
    output logic                                       valid,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]        selection,
    output logic [NUMBER_OF_QUEUES-1:0]                throttled,
    output logic                                       replenish
);

    localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);

    logic [PERIOD_SIZE-1:0]   pcnt;
    logic [REGISTER_SIZE-1:0] cnt   [NUMBER_OF_QUEUES];
    logic [REGISTER_SIZE-1:0] cnt_n [NUMBER_OF_QUEUES];

    logic                        boundary;
    logic [NUMBER_OF_QUEUES-1:0] hit;
    logic [NUMBER_OF_QUEUES-1:0] elig;
    logic [NUMBER_OF_QUEUES-1:0] thr_n;
    logic [NUMBER_OF_QUEUES-1:0] cand;
    logic                        found;
    logic [SEL_W-1:0]            best;
    logic [PRIORITY_SIZE-1:0]    best_pri;

    // The >= test lets a shrinking period take effect on the very next edge.
    always_comb begin
        boundary = (period != '0) && (pcnt >= period - PERIOD_SIZE'(1));
    end

    // Eligibility is judged on the next-state count so the registered grant never over-issues.
    always_comb begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            hit[i] = update & valid & (selection == SEL_W'(i));
            if (boundary)
                cnt_n[i] = hit[i] ? REGISTER_SIZE'(1) : '0;
            else if (cnt[i] == '1)
                cnt_n[i] = cnt[i];
            else
                cnt_n[i] = cnt[i] + REGISTER_SIZE'(hit[i]);
            thr_n[i] = (budgets[i*REGISTER_SIZE +: REGISTER_SIZE] != '0) && (period != '0) &&
                       (cnt_n[i] >= budgets[i*REGISTER_SIZE +: REGISTER_SIZE]);
            elig[i]  = ~empty[i] & ~thr_n[i];
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cand = elig;
`ifdef MEMGUARD_RECLAIM_EN
        // Idle memory: let throttled non-empty queues soak up the slack.
        if (elig == '0)
            cand = ~empty;
`endif
        found    = 1'b0;
        best     = '0;
        best_pri = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (cand[i] && (!found || priorities[i*PRIORITY_SIZE +: PRIORITY_SIZE] > best_pri)) begin
                found    = 1'b1;
                best     = SEL_W'(i);
                best_pri = priorities[i*PRIORITY_SIZE +: PRIORITY_SIZE];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pcnt      <= '0;
            valid     <= 1'b0;
            selection <= '0;
            throttled <= '0;
            replenish <= 1'b0;
            // NOTE: the usage counters are flops, not RAM, so they are reset with the rest of the state.
            for (int i = 0; i < NUMBER_OF_QUEUES; i++)
                cnt[i] <= '0;
        end else begin
            pcnt      <= boundary ? '0 : (period == '0 ? '0 : pcnt + PERIOD_SIZE'(1));
            valid     <= found;
            if (found)
                selection <= best;
            throttled <= thr_n;
            replenish <= boundary;
            for (int i = 0; i < NUMBER_OF_QUEUES; i++)
                cnt[i] <= cnt_n[i];
        end
    end

endmodule

// File: doc/memguard_regulator.md
# memguard_regulator

Parametrised successor to the fixed-priority MemGuard arbiter. It enforces a per-queue transaction budget inside a programmable regulation period, replenishes all budgets at each period boundary, and grants the highest-priority eligible non-empty queue. It sits between the per-core request queues and the memory-side dispatcher in the MemorEDF scheduler, and issues one registered grant decision per cycle.

## Interface
Parameters:
- NUMBER_OF_QUEUES, 4, number of regulated queues (≥2).
- REGISTER_SIZE, 16, width of each budget and usage counter.
- PRIORITY_SIZE, 4, width of each priority; a larger value means a higher priority.
- PERIOD_SIZE, 16, width of the period length and the period counter.

Ports:
- clock  in  1  single clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- budgets  in  NUMBER_OF_QUEUES×REGISTER_SIZE  transactions allowed per period for each queue; 0 means unlimited.
- priorities  in  NUMBER_OF_QUEUES×PRIORITY_SIZE  static priority of each queue.
- period  in  PERIOD_SIZE  regulation period in cycles; 0 disables regulation.
- empty  in  NUMBER_OF_QUEUES  queue i has no pending transaction.
- update  in  1  the transaction on `selection` was consumed this cycle; only meaningful while `valid`=1.
- valid  out  1  registered; `selection` holds a grantable queue.
- selection  out  $clog2(NUMBER_OF_QUEUES)  registered index of the granted queue.
- throttled  out  NUMBER_OF_QUEUES  registered; queue i has exhausted its budget this period.
- replenish  out  1  registered one-cycle pulse in the cycle after a period boundary.

## Operation
- Period counter `pcnt` (PERIOD_SIZE bits):
  - When `period`≠0 and `pcnt` ≥ `period`−1, the cycle is a boundary and `pcnt` is set to 0.
  - Otherwise `pcnt` increments.
  - Because the test is ≥, shrinking `period` takes effect at once.
  - When `period`=0, `pcnt` holds at 0 and no boundary occurs.
- Usage counter `cnt[i]`:
  - Charge: `hit[i]` = `update` & `valid` & (`selection`==i).
  - At a boundary, `cnt[i]` ← `hit[i]` ? 1 : 0. The charge is billed to the new period.
  - Otherwise `cnt[i]` ← `cnt[i]` + `hit[i]`, saturating at all-ones.
  - `update` while `valid`=0 is ignored and no counter changes.
- Eligibility uses the next-state counter `cnt_n[i]`, so no over-grant can occur from the registered decision:
  - `elig[i]` = ~`empty[i]` & (`budgets[i]`==0 | `period`==0 | `cnt_n[i]` < `budgets[i]`).
- Arbitration:
  - Among the `elig` queues, the highest `priorities[i]` wins.
  - Ties go to the lowest index.
  - Results are registered into `valid`/`selection`.
  - If no queue is eligible, `valid`←0 and `selection` holds its previous value.
- `throttled[i]` ← `budgets[i]`≠0 & `period`≠0 & `cnt_n[i]` ≥ `budgets[i]`.
- Budget changes mid-period are compared against the current count immediately. Lowering a budget below `cnt` throttles the queue at once.

## Timing
- All outputs reset to 0; `pcnt` and all `cnt` reset to 0. Reset assertion is asynchronous; deassertion is sampled synchronously.
- Grant latency: a change in `empty`/`budgets`/`priorities` at edge k appears on `valid`/`selection` after edge k+1.
- An `update` at edge k is reflected in `cnt`, `throttled` and `selection` after edge k+1 (one cycle).
- `replenish` is high for exactly one cycle, after the boundary edge. Its period is `period` cycles; for `period`=1, it is high every cycle.
- Back-to-back consumption is allowed: `update` may be high every cycle.
- Reset mid-period discards all usage and restarts the period at `pcnt`=0.

## Configuration
- MEMGUARD_RECLAIM_EN defined:
  - Enables slack reclamation. When no queue is eligible but some non-empty queue is throttled, arbitration runs over the non-empty throttled queues, still by priority with ties to the lowest index, and `valid`=1.
  - Reclaimed grants still charge `cnt`, with saturation.
- MEMGUARD_RECLAIM_EN undefined:
  - A throttled queue is never granted before the next boundary, even if the memory would otherwise be idle.

## Test plan
- Reset and idle: hold `reset`=0 for 3 cycles with all queues non-empty → `valid`=0, `selection`=0, `throttled`=0, `replenish`=0. Release reset → `valid`=1 after one edge.
- Budget exhaustion: `period`=20, budgets={2,2,2,2}, priorities={1,2,3,4}, all non-empty, `update` held high:
  - Without reclaim, grants are 3,3,2,2,1,1,0,0, then `valid`=0 until `replenish`.
  - `throttled` bits rise in the order 3,2,1,0.
- Unlimited budget: `budgets[1]`=0 with the highest priority → queue 1 is granted every cycle across 3 periods and is never throttled.
- Boundary collision: time `update` on queue 2 to coincide with the boundary edge → the next cycle shows `cnt[2]`=1, `replenish`=1, and the other counters at 0.
- Period change: `period` goes from 50 to 5 while `pcnt`=30 → boundary on the next edge, then a `replenish` pulse every 5 cycles. `period`=0 → no pulses and no throttling.
- Reclaim: with MEMGUARD_RECLAIM_EN defined, budgets={1,1,1,1}, all throttled and non-empty → `valid` stays 1 and queue 3 is granted until the boundary. With the macro undefined → `valid`=0.
